// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, oversampling
// ratio and parity mode selectors.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_seq_tick_counter.sv
// Loadable W-bit up-counter; o_max_tick flags an enabled cycle that lands on i_max.
module tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_max,
    output logic         o_max_tick
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_q <= '0;
        else if (i_load) r_q <= i_load_val;
        else if (i_en)   r_q <= r_q + 1'b1;
    end

    assign o_max_tick = i_en && (r_q == i_max);

endmodule

// File: rtl/uart_tx_seq.sv
// UART transmit sequencer: accepts a word over valid/ready and serializes a
// 16x-oversampled frame (start, data LSB-first, optional parity, stop).
module uart_tx_seq
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            tx_valid,
    input  logic [DBIT-1:0] din,
    output logic            tx_ready,
    output logic            tx_done_tick,
    output logic            tx_busy,
    output logic            tx
);

    localparam int SW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
    localparam int NW = $clog2(DBIT);

    tx_state_e       r_state, w_state_next;
    logic [DBIT-1:0] r_sh, w_sh_next;
    logic            r_par;
    logic            r_tx, w_tx_next;
    logic            w_accept;
    logic            w_s_end;
    logic            w_last_bit;
    logic            w_done;
    logic [SW-1:0]   w_s_max;

    assign w_accept = tx_valid && (r_state == ST_IDLE);
    assign w_s_max  = (r_state == ST_STOP) ? SW'(SB_TICK - 1) : SW'(OVERSAMPLE - 1);

    // s also clears at every bit boundary: DATA->DATA keeps the state but
    // s is wider than 4 bits when SB_TICK > 16, so it cannot rely on wrap.
    tick_counter #(.W(SW)) u_s_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (s_tick && (r_state != ST_IDLE)),
        .i_load     ((w_state_next != r_state) || w_s_end),
        .i_load_val ('0),
        .i_max      (w_s_max),
        .o_max_tick (w_s_end)
    );

    tick_counter #(.W(NW)) u_n_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       ((r_state == ST_DATA) && w_s_end),
        .i_load     (w_accept),
        .i_load_val ('0),
        .i_max      (NW'(DBIT - 1)),
        .o_max_tick (w_last_bit)
    );

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_START;
            ST_START: if (w_s_end) w_state_next = ST_DATA;
            ST_DATA:  if (w_last_bit)
                          w_state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            ST_PAR:   if (w_s_end) w_state_next = ST_STOP;
            ST_STOP:  if (w_s_end) begin
                          w_state_next = ST_IDLE;
                          w_done       = 1'b1;
                      end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sh_next = r_sh;
        if (w_accept)                             w_sh_next = din;
        else if ((r_state == ST_DATA) && w_s_end) w_sh_next = r_sh >> 1;
    end

    // tx is driven from next-state values so the line register flips on the
    // same edge as the state it belongs to.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_sh_next[0];
            ST_PAR:   w_tx_next = r_par;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_sh    <= w_sh_next;
            r_tx    <= w_tx_next;
            if (w_accept) r_par <= (^din) ^ (PARITY == PAR_ODD);
        end
    end

    assign tx           = r_tx;
    assign tx_ready     = (r_state == ST_IDLE);
    assign tx_busy      = (r_state != ST_IDLE);
    assign tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: four configurations checked every cycle against a
// frame-level model, plus directed literal checks.
module tb_uart_tx_seq;

    localparam int NU = 4;

    function automatic int pcfg(input int u);
        return (u == 1) ? 1 : (u == 2) ? 2 : 0;
    endfunction
    function automatic int scfg(input int u);
        return (u == 3) ? 32 : 16;
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick       [NU];
    logic       tx_valid     [NU];
    logic [7:0] din          [NU];
    logic       tx_ready     [NU];
    logic       tx_done_tick [NU];
    logic       tx_busy      [NU];
    logic       tx           [NU];
    bit         tick_en      [NU];

    int total = 0;
    int bad   = 0;
    int divcnt = 0;

    always #5 clk = ~clk;

    uart_tx_seq #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
        .clk(clk), .rst(rst), .s_tick(s_tick[0]), .tx_valid(tx_valid[0]), .din(din[0]),
        .tx_ready(tx_ready[0]), .tx_done_tick(tx_done_tick[0]), .tx_busy(tx_busy[0]), .tx(tx[0]));
    uart_tx_seq #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .s_tick(s_tick[1]), .tx_valid(tx_valid[1]), .din(din[1]),
        .tx_ready(tx_ready[1]), .tx_done_tick(tx_done_tick[1]), .tx_busy(tx_busy[1]), .tx(tx[1]));
    uart_tx_seq #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .s_tick(s_tick[2]), .tx_valid(tx_valid[2]), .din(din[2]),
        .tx_ready(tx_ready[2]), .tx_done_tick(tx_done_tick[2]), .tx_busy(tx_busy[2]), .tx(tx[2]));
    uart_tx_seq #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u3 (
        .clk(clk), .rst(rst), .s_tick(s_tick[3]), .tx_valid(tx_valid[3]), .din(din[3]),
        .tx_ready(tx_ready[3]), .tx_done_tick(tx_done_tick[3]), .tx_busy(tx_busy[3]), .tx(tx[3]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: a frame is a list of line bits, each held for 16 ticks,
    // followed by SB_TICK ticks of idle-high stop; k counts ticks consumed.
    bit          m_busy [NU];
    int          m_k    [NU];
    int          m_nb   [NU];
    int          m_len  [NU];
    logic [10:0] m_bits [NU];

    always @(negedge clk) begin
        logic etx, edone;
        for (int u = 0; u < NU; u++) begin
            if (rst) m_busy[u] = 1'b0;
            etx   = 1'b1;
            if (m_busy[u] && (m_k[u] / 16) < m_nb[u]) etx = m_bits[u][m_k[u] / 16];
            edone = m_busy[u] && s_tick[u] && (m_k[u] == m_len[u] - 1);
            chk($sformatf("u%0d tx", u),       tx[u],           etx);
            chk($sformatf("u%0d ready", u),    tx_ready[u],     !m_busy[u]);
            chk($sformatf("u%0d busy", u),     tx_busy[u],      m_busy[u]);
            chk($sformatf("u%0d done", u),     tx_done_tick[u], edone);
            if (!rst) begin
                if (!m_busy[u]) begin
                    if (tx_valid[u]) begin
                        m_busy[u] = 1'b1;
                        m_k[u]    = 0;
                        m_bits[u] = '0;
                        for (int i = 0; i < 8; i++) m_bits[u][1 + i] = din[u][i];
                        m_nb[u] = 9;
                        if (pcfg(u) != 0) begin
                            m_bits[u][9] = (^din[u]) ^ (pcfg(u) == 2);
                            m_nb[u] = 10;
                        end
                        m_len[u] = 16 * m_nb[u] + scfg(u);
                    end
                end else if (s_tick[u]) begin
                    if (m_k[u] == m_len[u] - 1) m_busy[u] = 1'b0;
                    else m_k[u]++;
                end
            end
        end
    end

    // Advance one clock; inputs change just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        divcnt++;
        for (int u = 0; u < NU; u++) s_tick[u] = tick_en[u] && (divcnt % 4 == 0);
    endtask

    task automatic frame(input int u, input logic [7:0] d, input int stall_at, input int stall_len,
                         output logic [11:0] seq, output int ticks, output bit hold_bad);
        int cnt, stalled;
        bit fin, did;
        seq = '0; cnt = 0; fin = 0; did = 0; stalled = 0; hold_bad = 0;
        din[u] = d;
        tx_valid[u] = 1'b1;
        cyc();
        tx_valid[u] = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(negedge clk);
            if (s_tick[u] && (cnt % 16 == 8) && (cnt / 16 < 12)) seq[cnt / 16] = tx[u];
            if (s_tick[u]) cnt++;
            if (tx_done_tick[u]) fin = 1;
            if (stalled > 0) begin
                if (tx[u] !== 1'b1 || tx_busy[u] !== 1'b1 || tx_done_tick[u] !== 1'b0) hold_bad = 1;
                stalled--;
                if (stalled == 0) tick_en[u] = 1'b1;
            end else if (stall_at >= 0 && cnt == stall_at && !did) begin
                did = 1;
                tick_en[u] = 1'b0;
                stalled = stall_len;
            end
            cyc();
        end
        chk($sformatf("u%0d frame finished", u), fin, 1'b1);
        ticks = cnt;
    endtask

    initial begin
        logic [11:0] seq;
        int          ticks, nd, gap, cnt;
        bit          hb;
        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            s_tick[u] = 1'b0; tx_valid[u] = 1'b0; din[u] = '0; tick_en[u] = 1'b1;
        end
        repeat (3) cyc();
        rst = 1'b0;

        // idle with ticks running
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_done_tick[0]) nd++;
            cyc();
        end
        chk("idle done count", nd, 0);
        chk("idle tx", tx[0], 1'b1);
        chk("idle ready", tx_ready[0], 1'b1);

        // A5, no parity: bits 0,1,0,1,0,0,1,0,1,1 (index 0 first)
        frame(0, 8'hA5, -1, 0, seq, ticks, hb);
        chk("A5 bits", seq[9:0], 10'b11_0100_1010);
        chk("A5 ticks", ticks, 160);

        // parity: ^07 = 1
        frame(1, 8'h07, -1, 0, seq, ticks, hb);
        chk("even par bit", seq[9], 1'b1);
        chk("even data+start", seq[8:0], 9'b0_0000_1110);
        chk("even ticks", ticks, 176);
        frame(2, 8'h07, -1, 0, seq, ticks, hb);
        chk("odd par bit", seq[9], 1'b0);
        chk("odd ticks", ticks, 176);

        // back-to-back with din change mid-frame
        din[0] = 8'h55; tx_valid[0] = 1'b1; nd = 0; gap = 0;
        for (int c = 0; c < 3000 && nd < 2; c++) begin
            @(negedge clk);
            if (tx_done_tick[0]) nd++;
            else if (nd == 1 && !tx_busy[0]) gap++;
            cyc();
            if (c == 100) din[0] = 8'hAA;
        end
        tx_valid[0] = 1'b0;
        chk("b2b frames", nd, 2);
        chk("b2b idle gap", gap, 1);

        // reset during DATA bit 3 of A5 (that bit is 0)
        din[0] = 8'hA5; tx_valid[0] = 1'b1;
        cyc();
        tx_valid[0] = 1'b0; cnt = 0;
        for (int c = 0; c < 2000 && cnt < 68; c++) begin
            @(negedge clk);
            if (s_tick[0]) cnt++;
            cyc();
        end
        chk("pre-reset tx", tx[0], 1'b0);
        rst = 1'b1;
        #1;
        chk("async reset tx", tx[0], 1'b1);
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset ready", tx_ready[0], 1'b1);
        chk("post-reset busy", tx_busy[0], 1'b0);
        cyc();
        frame(0, 8'h3C, -1, 0, seq, ticks, hb);
        chk("3C bits", seq[9:0], 10'b10_0111_1000);
        chk("3C ticks", ticks, 160);

        // 2 stop bits, stall mid-stop for 100 clk
        frame(3, 8'h0F, 154, 100, seq, ticks, hb);
        chk("stall hold", hb, 1'b0);
        chk("sb32 ticks", ticks, 176);
        chk("sb32 bits", seq[9:0], 10'b10_0001_1110);

        repeat (5) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
